// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
// State encoding and beat counter sizing.
package sdram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_WR_BURST = 3'd2,
        ST_RD_BURST = 3'd3,
        ST_DONE     = 3'd4
    } arb_state_t;

    // One bit wider than the length field so 256 beats never wrap.
    localparam int BEAT_W = 9;
    localparam int LEN_W  = 8;

endpackage

// File: rtl/sdram_port_arbiter.sv
// Arbitrates one write port and one read port onto a single-command
// SDRAM controller, steering the per-word handshake to the granted port.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int SDRAM_ADDRS_WIDE = 21,
    parameter int SDRAM_DATA_WIDE  = 32
) (
    input  logic                        i_sdram_clk,
    input  logic                        i_rst_n,
    input  logic                        i_wr_en,
    input  logic                        i_wr_force,
    input  logic [SDRAM_ADDRS_WIDE-1:0] i_wr_addrs,
    input  logic [LEN_W-1:0]            i_wr_lengths,
    input  logic [SDRAM_DATA_WIDE-1:0]  i_wr_data,
    output logic                        o_wr_data_req,
    output logic                        o_wr_done,
    input  logic                        i_rd_en,
    input  logic [SDRAM_ADDRS_WIDE-1:0] i_rd_addrs,
    input  logic [LEN_W-1:0]            i_rd_lengths,
    output logic [SDRAM_DATA_WIDE-1:0]  o_rd_data,
    output logic                        o_rd_data_vld,
    output logic                        o_rd_done,
    output logic                        o_ctrl_cmd_vld,
    output logic                        o_ctrl_cmd_wr,
    output logic [SDRAM_ADDRS_WIDE-1:0] o_ctrl_addrs,
    output logic [LEN_W-1:0]            o_ctrl_lengths,
    input  logic                        i_ctrl_cmd_rdy,
    input  logic                        i_ctrl_data_req,
    output logic [SDRAM_DATA_WIDE-1:0]  o_ctrl_wr_data,
    input  logic [SDRAM_DATA_WIDE-1:0]  i_ctrl_rd_data,
    input  logic                        i_ctrl_rd_data_vld,
    input  logic                        i_ctrl_done,
    output logic                        o_err
);

    localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

    arb_state_t        state;
    arb_state_t        state_nx;
    logic [BEAT_W-1:0] beat;
    logic [BEAT_W-1:0] len_ext;
    logic              last_wr;
    logic              req_any;
    logic              grant_wr;
    logic              in_range;
    logic              in_burst;
    logic              wr_pass;
    logic              wr_over;
    logic              rd_take;
    logic              rd_over;
    logic              done_bad;
    logic              err_set;

    // Force wins; otherwise a tie goes to whichever port was not served last.
    function automatic logic pick_wr(
        input logic wr_en,
        input logic rd_en,
        input logic force_wr,
        input logic prev_wr
    );
        logic res;
        if (!rd_en) begin
            res = wr_en;
        end else if (!wr_en) begin
            res = 1'b0;
        end else if (force_wr) begin
            res = 1'b1;
        end else begin
            res = ~prev_wr;
        end
        return res;
    endfunction

    assign req_any  = i_wr_en | i_rd_en;
    assign grant_wr = pick_wr(i_wr_en, i_rd_en, i_wr_force, last_wr);
    assign len_ext  = {{(BEAT_W-LEN_W){1'b0}}, o_ctrl_lengths};
    assign in_range = (beat <= len_ext);
    assign in_burst = (state == ST_WR_BURST) || (state == ST_RD_BURST);

    assign wr_pass = (state == ST_WR_BURST) && i_ctrl_data_req && in_range;
    assign wr_over = (state == ST_WR_BURST) && i_ctrl_data_req && !in_range;
    assign rd_take = (state == ST_RD_BURST) && i_ctrl_rd_data_vld && in_range;
    assign rd_over = (state == ST_RD_BURST) && i_ctrl_rd_data_vld && !in_range;

    always_comb begin
        done_bad = 1'b0;
        if (i_ctrl_done) begin
            if (in_burst) begin
                done_bad = (beat != (len_ext + BEAT_ONE));
            end else if (state == ST_IDLE || state == ST_CMD) begin
                done_bad = 1'b1;
            end
        end
    end

    assign err_set = wr_over | rd_over | done_bad;

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (req_any) begin
                    state_nx = ST_CMD;
                end
            end
            ST_CMD: begin
                if (i_ctrl_cmd_rdy) begin
                    state_nx = o_ctrl_cmd_wr ? ST_WR_BURST : ST_RD_BURST;
                end
            end
            ST_WR_BURST, ST_RD_BURST: begin
                if (i_ctrl_done) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Write data is a straight pass-through; the port FIFO latency is the
    // controller's concern, not ours.
    assign o_ctrl_cmd_vld = (state == ST_CMD);
    assign o_wr_data_req  = wr_pass;
    assign o_ctrl_wr_data = i_wr_data;
    assign o_wr_done      = (state == ST_DONE) && o_ctrl_cmd_wr;
    assign o_rd_done      = (state == ST_DONE) && !o_ctrl_cmd_wr;

    always_ff @(posedge i_sdram_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= ST_IDLE;
            beat           <= '0;
            last_wr        <= 1'b0;
            o_ctrl_cmd_wr  <= 1'b0;
            o_ctrl_addrs   <= '0;
            o_ctrl_lengths <= '0;
            o_rd_data      <= '0;
            o_rd_data_vld  <= 1'b0;
            o_err          <= 1'b0;
        end else begin
            state <= state_nx;

            if (state == ST_IDLE && req_any) begin
                o_ctrl_cmd_wr  <= grant_wr;
                o_ctrl_addrs   <= grant_wr ? i_wr_addrs : i_rd_addrs;
                o_ctrl_lengths <= grant_wr ? i_wr_lengths : i_rd_lengths;
            end

            if (state == ST_CMD && i_ctrl_cmd_rdy) begin
                beat    <= '0;
                last_wr <= o_ctrl_cmd_wr;
            end else if (wr_pass || rd_take) begin
                beat <= beat + BEAT_ONE;
            end

            o_rd_data_vld <= rd_take;
            if (rd_take) begin
                o_rd_data <= i_ctrl_rd_data;
            end

            if (err_set) begin
                o_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grants, data paths,
// protocol errors and reset mid-burst.
module tb_sdram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic        wr_force;
    logic [20:0] wr_addrs;
    logic [7:0]  wr_lengths;
    logic [31:0] wr_data;
    logic        wr_data_req;
    logic        wr_done;
    logic        rd_en;
    logic [20:0] rd_addrs;
    logic [7:0]  rd_lengths;
    logic [31:0] rd_data;
    logic        rd_data_vld;
    logic        rd_done;
    logic        cmd_vld;
    logic        cmd_wr;
    logic [20:0] ctrl_addrs;
    logic [7:0]  ctrl_lengths;
    logic        cmd_rdy;
    logic        data_req;
    logic [31:0] ctrl_wr_data;
    logic [31:0] ctrl_rd_data;
    logic        ctrl_rd_vld;
    logic        ctrl_done;
    logic        err;

    int total;
    int bad;
    int cyc;
    int wrq_cnt;
    int wdone_cnt;
    int rdone_cnt;
    int cmd_cyc;
    int done_cyc;
    int prev_done;
    int snap_a;
    int snap_b;

    sdram_port_arbiter #(
        .SDRAM_ADDRS_WIDE(21),
        .SDRAM_DATA_WIDE(32)
    ) dut (
        .i_sdram_clk       (clk),
        .i_rst_n           (rst_n),
        .i_wr_en           (wr_en),
        .i_wr_force        (wr_force),
        .i_wr_addrs        (wr_addrs),
        .i_wr_lengths      (wr_lengths),
        .i_wr_data         (wr_data),
        .o_wr_data_req     (wr_data_req),
        .o_wr_done         (wr_done),
        .i_rd_en           (rd_en),
        .i_rd_addrs        (rd_addrs),
        .i_rd_lengths      (rd_lengths),
        .o_rd_data         (rd_data),
        .o_rd_data_vld     (rd_data_vld),
        .o_rd_done         (rd_done),
        .o_ctrl_cmd_vld    (cmd_vld),
        .o_ctrl_cmd_wr     (cmd_wr),
        .o_ctrl_addrs      (ctrl_addrs),
        .o_ctrl_lengths    (ctrl_lengths),
        .i_ctrl_cmd_rdy    (cmd_rdy),
        .i_ctrl_data_req   (data_req),
        .o_ctrl_wr_data    (ctrl_wr_data),
        .i_ctrl_rd_data    (ctrl_rd_data),
        .i_ctrl_rd_data_vld(ctrl_rd_vld),
        .i_ctrl_done       (ctrl_done),
        .o_err             (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc       = 0;
        wrq_cnt   = 0;
        wdone_cnt = 0;
        rdone_cnt = 0;
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_data_req) wrq_cnt <= wrq_cnt + 1;
        if (wr_done) wdone_cnt <= wdone_cnt + 1;
        if (rd_done) rdone_cnt <= rdone_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_cmd(input string tag);
        int k;
        k = 0;
        while (cmd_vld !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk({tag, "_cmdvld"}, 64'(cmd_vld), 64'(1));
        cmd_cyc = cyc;
    endtask

    // Requests must already be driven; waits for the grant, runs nb beats,
    // then ends the burst and checks the done pulse.
    task automatic burst(input string tag, input bit exp_wr,
                         input logic [20:0] exp_addr,
                         input logic [7:0] exp_len, input int nb);
        wait_cmd(tag);
        chk({tag, "_dir"}, 64'(cmd_wr), 64'(exp_wr));
        chk({tag, "_addr"}, 64'(ctrl_addrs), 64'(exp_addr));
        chk({tag, "_len"}, 64'(ctrl_lengths), 64'(exp_len));
        tick();
        for (int i = 0; i < nb; i++) begin
            if (exp_wr) begin
                data_req = 1'b1;
                wr_data  = 32'h5A00_0000 + 32'(i);
            end else begin
                ctrl_rd_vld  = 1'b1;
                ctrl_rd_data = 32'hB000_0000 + 32'(i);
            end
            if (i == 0 && exp_wr) begin
                #1;
                chk({tag, "_wdata"}, 64'(ctrl_wr_data), 64'h5A00_0000);
            end
            tick();
        end
        data_req    = 1'b0;
        ctrl_rd_vld = 1'b0;
        ctrl_done   = 1'b1;
        tick();
        ctrl_done = 1'b0;
        done_cyc  = cyc;
        chk({tag, "_done"}, 64'(exp_wr ? wr_done : rd_done), 64'(1));
        chk({tag, "_odone"}, 64'(exp_wr ? rd_done : wr_done), 64'(0));
        tick();
        chk({tag, "_donelo"}, 64'(wr_done | rd_done), 64'(0));
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        wr_force     = 1'b0;
        wr_addrs     = '0;
        wr_lengths   = '0;
        wr_data      = '0;
        rd_en        = 1'b0;
        rd_addrs     = '0;
        rd_lengths   = '0;
        cmd_rdy      = 1'b1;
        data_req     = 1'b0;
        ctrl_rd_data = '0;
        ctrl_rd_vld  = 1'b0;
        ctrl_done    = 1'b0;

        #2;
        chk("rst_cmdvld", 64'(cmd_vld), 64'(0));
        chk("rst_cmdwr", 64'(cmd_wr), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_addr", 64'(ctrl_addrs), 64'(0));
        chk("rst_rdvld", 64'(rd_data_vld), 64'(0));
        chk("rst_done", 64'(wr_done | rd_done), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // 1: single 128-word write burst
        snap_a     = wrq_cnt;
        snap_b     = wdone_cnt;
        wr_en      = 1'b1;
        wr_addrs   = 21'h000100;
        wr_lengths = 8'd127;
        burst("t1", 1'b1, 21'h000100, 8'd127, 128);
        wr_en = 1'b0;
        chk("t1_reqcnt", 64'(wrq_cnt - snap_a), 64'(128));
        chk("t1_donecnt", 64'(wdone_cnt - snap_b), 64'(1));
        chk("t1_err", 64'(err), 64'(0));
        tick();

        // 4: read path, words with gaps, 1-cycle latency
        rd_en      = 1'b1;
        rd_addrs   = 21'h000200;
        rd_lengths = 8'd3;
        wait_cmd("t4");
        chk("t4_dir", 64'(cmd_wr), 64'(0));
        tick();
        for (int i = 0; i < 4; i++) begin
            ctrl_rd_vld  = 1'b1;
            ctrl_rd_data = 32'hA0 + 32'(i);
            tick();
            ctrl_rd_vld = 1'b0;
            #1;
            chk("t4_vld", 64'(rd_data_vld), 64'(1));
            chk("t4_data", 64'(rd_data), 64'(32'hA0 + 32'(i)));
            chk("t4_nodone", 64'(rd_done), 64'(0));
            if (i != 1) begin
                tick();
                chk("t4_gap", 64'(rd_data_vld), 64'(0));
            end
        end
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        rd_en     = 1'b0;
        chk("t4_done", 64'(rd_done), 64'(1));
        chk("t4_err", 64'(err), 64'(0));
        tick();
        chk("t4_donelo", 64'(rd_done), 64'(0));

        // 2: both held, no force -> W, R, W with fixed gaps
        wr_en      = 1'b1;
        rd_en      = 1'b1;
        wr_addrs   = 21'h000010;
        rd_addrs   = 21'h000020;
        wr_lengths = 8'd0;
        rd_lengths = 8'd1;
        burst("t2a", 1'b1, 21'h000010, 8'd0, 1);
        prev_done = done_cyc;
        burst("t2b", 1'b0, 21'h000020, 8'd1, 2);
        chk("t2_gap1", 64'(cmd_cyc - prev_done), 64'(2));
        prev_done = done_cyc;
        burst("t2c", 1'b1, 21'h000010, 8'd0, 1);
        chk("t2_gap2", 64'(cmd_cyc - prev_done), 64'(2));

        // 3: last was write, force still wins
        wr_force = 1'b1;
        burst("t3", 1'b1, 21'h000010, 8'd0, 1);
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wr_force = 1'b0;
        chk("t3_err", 64'(err), 64'(0));
        tick();

        // 5a: overrun of a 2-word write
        snap_a     = wrq_cnt;
        wr_en      = 1'b1;
        wr_addrs   = 21'h000030;
        wr_lengths = 8'd1;
        wait_cmd("t5");
        tick();
        for (int i = 0; i < 3; i++) begin
            data_req = 1'b1;
            #1;
            chk("t5_req", 64'(wr_data_req), 64'(i < 2));
            tick();
        end
        data_req = 1'b0;
        chk("t5_err", 64'(err), 64'(1));
        chk("t5_passed", 64'(wrq_cnt - snap_a), 64'(2));
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        wr_en     = 1'b0;
        chk("t5_done", 64'(wr_done), 64'(1));
        tick();
        tick();
        chk("t5_sticky", 64'(err), 64'(1));

        // 5b: stray done in IDLE
        do_reset();
        chk("t5b_clr", 64'(err), 64'(0));
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        chk("t5b_err", 64'(err), 64'(1));
        chk("t5b_idle", 64'(cmd_vld), 64'(0));
        tick();

        // 6: reset after the 10th write beat
        do_reset();
        wr_en      = 1'b1;
        wr_addrs   = 21'h000040;
        wr_lengths = 8'd31;
        wait_cmd("t6");
        tick();
        for (int i = 0; i < 10; i++) begin
            data_req = 1'b1;
            tick();
        end
        data_req = 1'b0;
        snap_b   = wdone_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_cmdwr", 64'(cmd_wr), 64'(0));
        chk("t6_addr", 64'(ctrl_addrs), 64'(0));
        chk("t6_len", 64'(ctrl_lengths), 64'(0));
        data_req = 1'b1;
        #1;
        chk("t6_req", 64'(wr_data_req), 64'(0));
        data_req = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6_nodone", 64'(wdone_cnt - snap_b), 64'(0));
        burst("t6n", 1'b1, 21'h000040, 8'd31, 32);
        wr_en = 1'b0;
        chk("t6_donecnt", 64'(wdone_cnt - snap_b), 64'(1));
        chk("t6_err", 64'(err), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
